// File: rtl/ct_spsram_param_shadow.sv
// Parametrised single-port SRAM with post-reset clear sequencer and configurable read latency.
// Optional per-bit taint shadow array enabled by defining CT_SPSRAM_TAINT_EN.
module ct_spsram_param_shadow #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  BUSY,
  input  logic [ADDR_WIDTH-1:0] A_t0,
  input  logic                  CEN_t0,
  input  logic                  GWEN_t0,
  input  logic [DATA_WIDTH-1:0] WEN_t0,
  input  logic [DATA_WIDTH-1:0] D_t0,
  output logic [DATA_WIDTH-1:0] Q_t0
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [0:0] ST_RESET = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

  logic [0:0]            state;
  logic [0:0]            next_state;
  logic [IW-1:0]         cnt;
  logic [IW-1:0]         cnt_next;
  logic                  clr_we_c;
  logic                  in_range_c;
  logic [IW-1:0]         idx_c;
  logic                  acc_c;
  logic                  rd_c;
  logic                  wr_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic [DATA_WIDTH-1:0] rd_taint_c;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Clear sequencer state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_RESET;
      cnt   <= '0;
      BUSY  <= (INIT_CLEAR != 0);
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      BUSY  <= (next_state == ST_CLEAR);
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    clr_we_c   = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we_c = 1'b1;
        if (cnt == LAST_IDX) begin
          next_state = ST_READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + IW'(1);
        end
      end
      default: ;
    endcase
  end

  assign in_range_c = ({1'b0, A} < DEPTH_A);
  assign idx_c      = IW'(A);
  assign acc_c      = !RST && !BUSY && !CEN;
  assign rd_c       = acc_c && GWEN;
  assign wr_c       = acc_c && !GWEN && in_range_c;
  assign rd_data_c  = in_range_c ? mem[idx_c] : '0;

  // Data array; the reset cycle leaves contents untouched
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (clr_we_c) begin
        mem[cnt] <= '0;
      end else if (wr_c) begin
        mem[idx_c] <= (mem[idx_c] & WEN) | (D & ~WEN);
      end
    end
  end

`ifdef CT_SPSRAM_TAINT_EN
  logic                  ctrl_t_c;
  logic [DATA_WIDTH-1:0] ctrl_v_c;
  logic [DATA_WIDTH-1:0] taint [DEPTH];

  assign ctrl_t_c   = CEN_t0 | GWEN_t0 | (|A_t0);
  assign ctrl_v_c   = {DATA_WIDTH{ctrl_t_c}};
  assign rd_taint_c = in_range_c ? (taint[idx_c] | ctrl_v_c) : '0;

  // Masked-off bits still become tainted when their enable or the control path is tainted
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (clr_we_c) begin
        taint[cnt] <= '0;
      end else if (wr_c) begin
        taint[idx_c] <= (~WEN & (D_t0 | WEN_t0 | ctrl_v_c))
                      | ( WEN & (taint[idx_c] | WEN_t0 | ctrl_v_c));
      end
    end
  end
`else
  logic unused_t0;

  assign rd_taint_c = '0;
  assign unused_t0  = ^{A_t0, CEN_t0, GWEN_t0, WEN_t0, D_t0};
`endif

  // Read pipeline: Q only moves when a read result arrives
  if (RD_LAT == 2) begin : g_lat2
    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_q;
    logic [DATA_WIDTH-1:0] s1_qt;

    always_ff @(posedge CLK) begin
      if (RST) begin
        s1_vld <= 1'b0;
        s1_q   <= '0;
        s1_qt  <= '0;
        Q      <= '0;
        Q_t0   <= '0;
      end else begin
        s1_vld <= rd_c;
        if (rd_c) begin
          s1_q  <= rd_data_c;
          s1_qt <= rd_taint_c;
        end
        if (s1_vld) begin
          Q    <= s1_q;
          Q_t0 <= s1_qt;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge CLK) begin
      if (RST) begin
        Q    <= '0;
        Q_t0 <= '0;
      end else if (rd_c) begin
        Q    <= rd_data_c;
        Q_t0 <= rd_taint_c;
      end
    end
  end

endmodule

// File: tb/tb_ct_spsram_param_shadow.sv
// Directed bench for ct_spsram_param_shadow: two instances (RD_LAT=1 and RD_LAT=2) share stimulus.
module tb_ct_spsram_param_shadow;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 128;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] A;
  logic          CEN;
  logic          GWEN;
  logic [DW-1:0] WEN;
  logic [DW-1:0] D;
  logic [AW-1:0] A_t0;
  logic          CEN_t0;
  logic          GWEN_t0;
  logic [DW-1:0] WEN_t0;
  logic [DW-1:0] D_t0;

  logic [DW-1:0] q1, qt1, q2, qt2;
  logic          busy1, busy2;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [DW-1:0] ALL1 = {DW{1'b1}};
  localparam logic [DW-1:0] WA5  = {16{8'hA5}};
  localparam logic [DW-1:0] W1   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [DW-1:0] W2   = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
  localparam logic [DW-1:0] W4   = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
  localparam logic [DW-1:0] W9   = 128'h9999_0000_AAAA_5555_1234_5678_9ABC_DEF0;
  localparam logic [DW-1:0] PART = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic [DW-1:0] HIMASK = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

`ifdef CT_SPSRAM_TAINT_EN
  localparam logic [DW-1:0] EXP_T_CLEAN = 128'h1;
  localparam logic [DW-1:0] EXP_T_ADDR  = ALL1;
`else
  localparam logic [DW-1:0] EXP_T_CLEAN = '0;
  localparam logic [DW-1:0] EXP_T_ADDR  = '0;
`endif

  always #5 CLK = ~CLK;

  ct_spsram_param_shadow #(
    .ADDR_WIDTH(AW), .DEPTH(16), .DATA_WIDTH(DW), .RD_LAT(1), .INIT_CLEAR(1)
  ) u_lat1 (
    .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D),
    .Q(q1), .BUSY(busy1), .A_t0(A_t0), .CEN_t0(CEN_t0), .GWEN_t0(GWEN_t0),
    .WEN_t0(WEN_t0), .D_t0(D_t0), .Q_t0(qt1)
  );

  ct_spsram_param_shadow #(
    .ADDR_WIDTH(AW), .DEPTH(16), .DATA_WIDTH(DW), .RD_LAT(2), .INIT_CLEAR(1)
  ) u_lat2 (
    .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D),
    .Q(q2), .BUSY(busy2), .A_t0(A_t0), .CEN_t0(CEN_t0), .GWEN_t0(GWEN_t0),
    .WEN_t0(WEN_t0), .D_t0(D_t0), .Q_t0(qt2)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] w);
    A = a; D = d; WEN = w; GWEN = 1'b0; CEN = 1'b0;
    tick();
    CEN = 1'b1; GWEN = 1'b1;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    A = a; GWEN = 1'b1; CEN = 1'b0;
    tick();
    CEN = 1'b1;
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (busy1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, DW'(n), DW'(16));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; CEN = 1'b1; GWEN = 1'b1; A = '0; WEN = ALL1; D = '0;
    A_t0 = '0; CEN_t0 = 1'b0; GWEN_t0 = 1'b0; WEN_t0 = '0; D_t0 = '0;
    tick();
    RST = 1'b0;
    check("rst_busy1", DW'(busy1), DW'(1));
    check("rst_busy2", DW'(busy2), DW'(1));
    check("rst_q1", q1, '0);
    check("rst_q2", q2, '0);
    check("rst_qt1", qt1, '0);

    // read of A=5 held during clear must be dropped
    A = 5'd5; GWEN = 1'b1; CEN = 1'b0;
    wait_clear("clear_len");
    CEN = 1'b1;
    check("clear_busy2", DW'(busy2), DW'(0));
    check("busy_rd_q1", q1, '0);
    check("busy_rd_q2", q2, '0);
    tick();
    check("busy_rd_q2_late", q2, '0);

    wr(5'd3, WA5, '0);
    check("no_wthru_q1", q1, '0);
    rd(5'd3);
    check("rd3_lat1", q1, WA5);
    check("rd3_lat2_early", q2, '0);
    tick();
    check("rd3_lat2", q2, WA5);
    check("rd3_hold_q1", q1, WA5);

    rd(5'd5);
    check("cleared_q1", q1, '0);
    tick();
    check("cleared_q2", q2, '0);

    wr(5'd7, ALL1, HIMASK);
    rd(5'd7);
    check("part_q1", q1, PART);
    tick();
    check("part_q2", q2, PART);

    // back-to-back reads of 1,2,3
    wr(5'd1, W1, '0);
    wr(5'd2, W2, '0);
    A = 5'd1; GWEN = 1'b1; CEN = 1'b0;
    tick();
    check("b2b_e1_q1", q1, W1);
    check("b2b_e1_q2", q2, PART);
    A = 5'd2;
    tick();
    check("b2b_e2_q1", q1, W2);
    check("b2b_e2_q2", q2, W1);
    A = 5'd3;
    tick();
    check("b2b_e3_q1", q1, WA5);
    check("b2b_e3_q2", q2, W2);
    CEN = 1'b1;
    tick();
    check("b2b_e4_q2", q2, WA5);
    tick();
    check("b2b_idle_q1", q1, WA5);
    check("b2b_idle_q2", q2, WA5);

    // write then read the same address on the very next edge
    A = 5'd9; D = W9; WEN = '0; GWEN = 1'b0; CEN = 1'b0;
    tick();
    GWEN = 1'b1;
    tick();
    CEN = 1'b1;
    check("raw_q1", q1, W9);
    tick();
    check("raw_q2", q2, W9);

    // out-of-range write dropped (no alias onto A=4), read returns zero
    wr(5'd20, ALL1, '0);
    rd(5'd20);
    check("oor_q1", q1, '0);
    tick();
    check("oor_q2", q2, '0);
    rd(5'd3);
    tick();
    rd(5'd4);
    check("alias_q1", q1, '0);
    tick();
    check("alias_q2", q2, '0);

    // CEN=1 with GWEN=0 must not write
    A = 5'd3; D = '0; WEN = '0; GWEN = 1'b0; CEN = 1'b1;
    tick();
    GWEN = 1'b1;
    rd(5'd3);
    tick();
    check("cen_hi_q1", q1, WA5);
    check("cen_hi_q2", q2, WA5);

    // reset while a RD_LAT=2 read is in flight
    rd(5'd9);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_pend_q2", q2, '0);
    check("rst_pend_q1", q1, '0);
    check("rst_pend_busy", DW'(busy1), DW'(1));
    tick();
    check("rst_pend_stale_q2", q2, '0);
    repeat (6) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("restart_busy", DW'(busy1), DW'(1));
    wait_clear("restart_len");
    check("restart_busy2", DW'(busy2), DW'(0));

    rd(5'd9);
    check("reclear_q1", q1, '0);
    tick();
    check("reclear_q2", q2, '0);

    // taint tracking
    D_t0 = 128'h1;
    wr(5'd4, W4, '0);
    D_t0 = '0;
    rd(5'd4);
    check("t_clean_q1", q1, W4);
    check("t_clean_qt1", qt1, EXP_T_CLEAN);
    tick();
    check("t_clean_qt2", qt2, EXP_T_CLEAN);
    A_t0 = 5'h1;
    rd(5'd4);
    A_t0 = '0;
    check("t_addr_qt1", qt1, EXP_T_ADDR);
    tick();
    check("t_addr_qt2", qt2, EXP_T_ADDR);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
